// File: rtl/speck_pkg.sv
// Shared SPECK128 constants and the round-sequencer state encoding.
package speck_pkg;
  localparam int SPECK128_WORD   = 64;
  localparam int SPECK128_ROUNDS = 32;
  localparam int SPECK128_BLOCK  = 2 * SPECK128_WORD;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_KS_GO,
    ST_KS_WAIT,
    ST_RD_GO,
    ST_RD_WAIT,
    ST_NEXT,
    ST_DONE,
    ST_ERROR
  } seq_state_e;
endpackage

// File: rtl/speck_round_sequencer_if.sv
// Host handshake plus key-schedule / round-unit bus of the SPECK round sequencer.
interface speck_round_sequencer_if;
  import speck_pkg::*;

  logic                       start;
  logic [SPECK128_BLOCK-1:0]  key;
  logic [SPECK128_BLOCK-1:0]  plaintext;
  logic                       ready;
  logic                       busy;
  logic                       done;
  logic                       error;
  logic [SPECK128_BLOCK-1:0]  ciphertext;
  logic [5:0]                 round_idx;

  logic                       ks_start;
  logic [SPECK128_BLOCK-1:0]  ks_key;
  logic [SPECK128_WORD-1:0]   ks_round_ctr;
  logic                       ks_finished;
  logic [SPECK128_BLOCK-1:0]  ks_out_key;

  logic                       rd_start;
  logic [SPECK128_WORD-1:0]   rd_subkey;
  logic [SPECK128_BLOCK-1:0]  rd_plaintext;
  logic                       rd_finished;
  logic [SPECK128_BLOCK-1:0]  rd_ciphertext;

  // slave: the sequencer itself; master: host plus datapath units around it
  modport slave (
    input  start, key, plaintext, ks_finished, ks_out_key, rd_finished, rd_ciphertext,
    output ready, busy, done, error, ciphertext, round_idx,
           ks_start, ks_key, ks_round_ctr, rd_start, rd_subkey, rd_plaintext
  );
  modport master (
    output start, key, plaintext, ks_finished, ks_out_key, rd_finished, rd_ciphertext,
    input  ready, busy, done, error, ciphertext, round_idx,
           ks_start, ks_key, ks_round_ctr, rd_start, rd_subkey, rd_plaintext
  );
endinterface

// File: rtl/speck_wdog.sv
// Saturating 8-bit wait watchdog: load clears, cnt increments, expired at TIMEOUT.
module speck_wdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic cnt_i,
  output logic expired_o
);
  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)                        cnt_d = '0;
    else if (cnt_i && cnt_q != 8'hFF)  cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expired_o = (cnt_q == 8'(TIMEOUT));
endmodule

// File: rtl/speck_round_sequencer.sv
// Iterative SPECK128 controller: alternates key-schedule and round units per round,
// owning key/state feedback registers, round counter and wait watchdog.
module speck_round_sequencer
  import speck_pkg::*;
#(
  parameter int N_ROUNDS = SPECK128_ROUNDS,
  parameter int TIMEOUT  = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  speck_round_sequencer_if.slave  sif
);
  localparam logic [5:0] LAST_IDX = 6'(N_ROUNDS - 1);

  seq_state_e                 state_q, state_d;
  logic [SPECK128_BLOCK-1:0]  k_q, k_d;
  logic [SPECK128_BLOCK-1:0]  s_q, s_d;
  logic [SPECK128_BLOCK-1:0]  ct_q, ct_d;
  logic [5:0]                 ridx_q, ridx_d;
  logic                       err_q, err_d;
  logic                       wd_load, wd_cnt, wd_exp;

  speck_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk       (clk),
    .rst       (rst),
    .load_i    (wd_load),
    .cnt_i     (wd_cnt),
    .expired_o (wd_exp)
  );

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    s_d     = s_q;
    ct_d    = ct_q;
    ridx_d  = ridx_q;
    err_d   = err_q;
    wd_load = 1'b0;
    wd_cnt  = 1'b0;
    unique case (state_q)
      ST_IDLE: if (sif.start) begin
        k_d     = sif.key;
        s_d     = sif.plaintext;
        ridx_d  = '0;
        err_d   = 1'b0;
        state_d = ST_KS_GO;
      end
      ST_KS_GO: begin
        wd_load = 1'b1;
        state_d = ST_KS_WAIT;
      end
      // finished has priority over an expiring watchdog in the same cycle
      ST_KS_WAIT: begin
        if (sif.ks_finished) begin
          k_d     = sif.ks_out_key;
          state_d = ST_RD_GO;
        end else if (wd_exp) begin
          state_d = ST_ERROR;
        end else begin
          wd_cnt = 1'b1;
        end
      end
      ST_RD_GO: begin
        wd_load = 1'b1;
        state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (sif.rd_finished) begin
          s_d     = sif.rd_ciphertext;
          state_d = ST_NEXT;
        end else if (wd_exp) begin
          state_d = ST_ERROR;
        end else begin
          wd_cnt = 1'b1;
        end
      end
      ST_NEXT: begin
        if (ridx_q == LAST_IDX) begin
          ct_d    = s_q;
          state_d = ST_DONE;
        end else begin
          ridx_d  = ridx_q + 6'd1;
          state_d = ST_KS_GO;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      ST_ERROR: begin
        err_d   = 1'b1;
        state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      s_q     <= '0;
      ct_q    <= '0;
      ridx_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      s_q     <= s_d;
      ct_q    <= ct_d;
      ridx_q  <= ridx_d;
      err_q   <= err_d;
    end
  end

  assign sif.ready        = (state_q == ST_IDLE);
  assign sif.busy         = !(state_q inside {ST_IDLE, ST_DONE, ST_ERROR});
  assign sif.done         = (state_q == ST_DONE);
  assign sif.error        = err_q;
  assign sif.ciphertext   = ct_q;
  assign sif.round_idx    = ridx_q;
  assign sif.ks_start     = (state_q == ST_KS_GO);
  assign sif.ks_key       = k_q;
  assign sif.ks_round_ctr = {{(SPECK128_WORD-6){1'b0}}, ridx_q};
  assign sif.rd_start     = (state_q == ST_RD_GO);
  assign sif.rd_subkey    = k_q[SPECK128_BLOCK-1:SPECK128_WORD];
  assign sif.rd_plaintext = s_q;
endmodule
